seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed, parametrised seven-segment display driver.
- Latches a packed hex word of DIGITS nibbles and scans one digit at a time onto a shared segment bus with per-digit anode enables.
- Provides per-digit enable, decimal points, leading-zero suppression and an inter-digit blanking gap to prevent ghosting.
- Sits between the CPU's display I/O register and the board's display pins.

Parameters:
- DIGITS, 4, number of digits scanned; legal range 1..8.
- PRESCALE, 50000, clock cycles per digit slot (blank plus show); must be >= 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; 0 <= BLANK_CYCLES < PRESCALE.
- SEG_ACTIVE_LOW, 1, 1 means segment and dp outputs drive 0 to light.
- AN_ACTIVE_LOW, 1, 1 means an outputs drive 0 to enable a digit.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- value, in, 4*DIGITS, packed hex digits; digit i is value[4i+3:4i], and digit 0 is the rightmost.
- load, in, 1, when high, value, dp_in and digit_en are captured into shadow registers on this edge.
- dp_in, in, DIGITS, per-digit decimal point request.
- digit_en, in, DIGITS, per-digit enable; 0 keeps that digit dark.
- lz_suppress, in, 1, leading-zero suppression enable, sampled live.
- seg, out, 7, segments a..g, with seg[6]=a and seg[0]=g.
- dp_out, out, 1, decimal point segment.
- an, out, DIGITS, digit enables; an[i] drives digit i.
- frame_start, out, 1, one-cycle pulse on entry to BLANK for digit 0.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; it takes effect immediately, without a clock edge.
- Reset values:
  - an all inactive; seg all off (7'b1111111 when SEG_ACTIVE_LOW); dp_out off; frame_start 0.
  - Shadow value, dp and digit_en registers all 0.
  - Digit index 0, slot counter 0, state BLANK.
- All outputs are registered and change together with the state registers. There are no combinational paths from inputs to outputs.
- Shadow registers:
  - Load on any edge where load=1; no other qualification.
  - Scanning always uses the shadow registers, never the live value, dp_in or digit_en inputs.
- FSM states:
  - BLANK: lasts BLANK_CYCLES cycles. an all inactive, seg off, dp off.
  - SHOW: lasts PRESCALE-BLANK_CYCLES cycles. an[idx] is active if the digit is visible; seg and dp are held constant for the whole SHOW.
- Transitions:
  - BLANK -> SHOW when the counter reaches BLANK_CYCLES-1.
  - SHOW -> BLANK when the counter reaches PRESCALE-1. The counter clears, and idx goes to idx+1, wrapping from DIGITS-1 to 0.
  - If BLANK_CYCLES=0, BLANK is skipped: SHOW -> SHOW with idx advance.
  - The first slot after reset release is BLANK for digit 0; frame_start pulses in that first cycle.
- seg and dp are sampled from the shadow registers only on the edge that enters SHOW. A load during SHOW therefore does not alter the current digit.
- Visibility rule for digit i:
  - The digit is invisible if digit_en_q[i]=0.
  - The digit is invisible if lz_suppress=1, i>0, and nibbles DIGITS-1 down to i are all zero.
  - Digit 0 is never suppressed by the leading-zero rule.
  - An invisible digit keeps an inactive, seg off and dp off for its whole slot. The slot timing is unchanged.
- Glyphs, in active-low a..g form (inverted when SEG_ACTIVE_LOW=0):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Frame period is DIGITS*PRESCALE cycles, and frame_start is exactly periodic with that period.
- An out-of-range parameter stops elaboration through a $fatal in an initial block.

Decomposition:
- seg7_pkg:
  - Enum scan_state_t {BLANK, SHOW}.
  - Constant array SEG7_HEX[16] of active-low glyphs.
  - Constant SEG7_OFF = 7'b1111111.
- Sub-module hex_to_seg7: combinational, 4-bit nibble in, 7-bit active-low glyph out, using SEG7_HEX.
- The top level applies the SEG_ACTIVE_LOW inversion.

Test Plan:
All scenarios use DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
1. Reset state: hold reset, then release. During reset an=1111, seg=1111111, dp_out=1. After release, frame_start pulses in the first cycle, and the first SHOW begins on the 3rd post-reset cycle.
2. Basic scan: load value=16'h1234 with digit_en=F, lz_suppress=0.
   - Digit slots show an=1110 with seg=1001100, then an=1101 with 0000110, then an=1011 with 0010010, then an=0111 with 1001111.
   - Each SHOW lasts 6 cycles and each gap 2 cycles; frame_start repeats every 32 cycles.
3. Leading-zero suppression, lz_suppress=1:
   - value=16'h00A0: digits 3 and 2 stay dark (an=1111 in their slots), digit 1 shows 0001000, digit 0 shows 0000001.
   - value=0: only digit 0 is lit, showing 0000001.
4. Enable and decimal points: load digit_en=4'b0101 with dp_in=4'b0100. Digit 2 is lit with dp_out=0; digits 1 and 3 are dark; digit 0 is lit with dp_out=1.
5. Load mid-SHOW: while digit 0 shows 4, load 16'h123F. seg holds 1001100 until the next SHOW of digit 0, which shows 0111000.
6. Reset mid-SHOW: assert reset between clock edges. an, seg and dp go inactive immediately, and the scan restarts at digit 0 in BLANK.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared types and constants for the seven-segment scan driver.
//   - scan_state_t : slot phase of the scanner (BLANK gap, then SHOW).
//   - SEG7_HEX     : active-low a..g glyphs for hex digits 0..F,
//                    bit 6 = segment a, bit 0 = segment g.
//   - SEG7_OFF     : active-low "all segments dark" pattern.
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG7_OFF = 7'b1111111;

  // Entry n is the glyph for hex digit n (active-low, a..g).
  localparam logic [6:0] SEG7_HEX [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
//   Combinational hex nibble to seven-segment glyph decoder.
//   Ports:
//     nibble : in  [3:0]  hex digit 0..F
//     glyph  : out [6:0]  active-low a..g pattern (glyph[6] = a, glyph[0] = g)
//   Output polarity is fixed active-low; the caller adapts it to the board.
// -----------------------------------------------------------------------------
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = SEG7_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed seven-segment display driver. A packed hex word is
//   captured into shadow registers on load and scanned one digit per slot.
//   Each slot is BLANK (all anodes off, anti-ghosting gap) followed by SHOW
//   (one anode on, segments held constant). Digits can be individually
//   disabled, carry a decimal point, and leading zeros can be suppressed.
//
//   Parameters:
//     DIGITS         digits scanned (1..8)
//     PRESCALE       cycles per digit slot, blank + show (>= 2)
//     BLANK_CYCLES   dark cycles at the start of each slot (< PRESCALE)
//     SEG_ACTIVE_LOW 1: seg/dp_out drive 0 to light
//     AN_ACTIVE_LOW  1: an drives 0 to enable a digit
//
//   Ports:
//     clk          in   system clock
//     reset        in   asynchronous active-high reset
//     value        in   [4*DIGITS-1:0] packed hex digits, digit 0 rightmost
//     load         in   capture value/dp_in/digit_en into shadow registers
//     dp_in        in   [DIGITS-1:0] per-digit decimal point request
//     digit_en     in   [DIGITS-1:0] per-digit enable
//     lz_suppress  in   leading-zero suppression, sampled live
//     seg          out  [6:0] segments a..g (seg[6] = a)
//     dp_out       out  decimal point segment
//     an           out  [DIGITS-1:0] digit enables
//     frame_start  out  one-cycle pulse when the slot of digit 0 begins
//
//   All outputs are registered; nothing passes combinationally from an
//   input to an output.
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_suppress,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  initial begin
    if (DIGITS < 1 || DIGITS > 8)
      $fatal(1, "seg7_scan_driver: DIGITS=%0d outside 1..8", DIGITS);
    if (PRESCALE < 2)
      $fatal(1, "seg7_scan_driver: PRESCALE=%0d must be >= 2", PRESCALE);
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= PRESCALE)
      $fatal(1, "seg7_scan_driver: BLANK_CYCLES=%0d must be in 0..PRESCALE-1",
             BLANK_CYCLES);
  end

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  // Output idle levels in board polarity.
  localparam logic [6:0]        SEG_OFF_OUT = (SEG_ACTIVE_LOW != 0) ? SEG7_OFF : 7'b0000000;
  localparam logic              DP_OFF      = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF      = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                   : {DIGITS{1'b0}};

  // ---------------------------------------------------------------------------
  // Shadow registers
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   en_q;

  // NOTE: these are plain registers, not a RAM, so clearing them on reset is
  // cheap and guarantees a dark display until software writes a value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      dp_q    <= '0;
      en_q    <= '0;
    end else if (load) begin
      value_q <= value;
      dp_q    <= dp_in;
      en_q    <= digit_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan state
  // ---------------------------------------------------------------------------
  scan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  // Clear while in reset; the first edge after release starts the frame so
  // frame_start can pulse during the first slot cycle.
  logic             running;

  logic [IDX_W-1:0] idx_next;
  assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // Digit whose SHOW would be entered on this edge: digit 0 on start-up,
  // the current digit when leaving BLANK, the next digit when BLANK_CYCLES=0
  // makes SHOW flow straight into the following SHOW.
  logic [IDX_W-1:0] tgt_idx;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    tgt_idx = idx;
    if (!running)
      tgt_idx = '0;
    else if (state == SHOW)
      tgt_idx = idx_next;
  end

  // ---------------------------------------------------------------------------
  // Visibility of the target digit
  // ---------------------------------------------------------------------------
  // upper_zero[i] is set when nibbles DIGITS-1 down to i are all zero.
  logic [DIGITS:0] upper_zero;
  always_comb begin
    upper_zero         = '0;
    upper_zero[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--)
      upper_zero[i] = upper_zero[i+1] && (value_q[4*i +: 4] == 4'h0);
  end

  logic visible;
  assign visible = en_q[tgt_idx] &&
                   !(lz_suppress && (tgt_idx != '0) && upper_zero[tgt_idx]);

  // ---------------------------------------------------------------------------
  // Glyph decode and board-polarity outputs for the SHOW being entered
  // ---------------------------------------------------------------------------
  logic [3:0] tgt_nibble;
  logic [6:0] tgt_glyph;

  assign tgt_nibble = value_q[4*tgt_idx +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (tgt_nibble),
    .glyph  (tgt_glyph)
  );

  logic [DIGITS-1:0] an_sel;
  logic [DIGITS-1:0] an_show;
  logic [6:0]        seg_show;
  logic              dp_show;

  always_comb begin
    an_sel          = '0;
    an_sel[tgt_idx] = visible;

    an_show = (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;

    seg_show = SEG_OFF_OUT;
    if (visible)
      seg_show = (SEG_ACTIVE_LOW != 0) ? tgt_glyph : ~tgt_glyph;

    dp_show = DP_OFF;
    if (visible && dp_q[tgt_idx])
      dp_show = ~DP_OFF;
  end

  // ---------------------------------------------------------------------------
  // Scan FSM with registered outputs
  // ---------------------------------------------------------------------------
  // SHOW counts from BLANK_CYCLES to PRESCALE-1; BLANK counts from 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= '0;
      running     <= 1'b0;
      an          <= AN_OFF;
      seg         <= SEG_OFF_OUT;
      dp_out      <= DP_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;

      if (!running) begin
        // First slot after reset: digit 0, counter from zero.
        running     <= 1'b1;
        frame_start <= 1'b1;
        cnt         <= '0;
        idx         <= '0;
        if (BLANK_CYCLES == 0) begin
          state  <= SHOW;
          an     <= an_show;
          seg    <= seg_show;
          dp_out <= dp_show;
        end else begin
          state  <= BLANK;
          an     <= AN_OFF;
          seg    <= SEG_OFF_OUT;
          dp_out <= DP_OFF;
        end
      end else begin
        unique case (state)
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_LAST) begin
              state  <= SHOW;
              an     <= an_show;
              seg    <= seg_show;
              dp_out <= dp_show;
            end
          end

          SHOW: begin
            if (cnt == SLOT_LAST) begin
              cnt         <= '0;
              idx         <= idx_next;
              frame_start <= (idx_next == '0);
              if (BLANK_CYCLES == 0) begin
                state  <= SHOW;
                an     <= an_show;
                seg    <= seg_show;
                dp_out <= dp_show;
              end else begin
                state  <= BLANK;
                an     <= AN_OFF;
                seg    <= SEG_OFF_OUT;
                dp_out <= DP_OFF;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state <= BLANK;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Self-checking bench for seg7_scan_driver with DIGITS=4, PRESCALE=8,
//   BLANK_CYCLES=2, active-low segments and anodes. A slot-timing model keyed
//   off the cycle count since reset release checks blanking and frame_start;
//   per-slot expectations are pushed to a queue when stimulus is driven and
//   popped when the corresponding SHOW begins.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   digit_en;
  logic                lz_suppress;
  logic [6:0]          seg;
  logic                dp_out;
  logic [DIGITS-1:0]   an;
  logic                frame_start;

  seg7_scan_driver #(
    .DIGITS         (DIGITS),
    .PRESCALE       (PRESCALE),
    .BLANK_CYCLES   (BLANK),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .load        (load),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .dp_out      (dp_out),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic exp_t ref_digit(input int i, input logic [15:0] v, input logic [3:0] dpv,
                                     input logic [3:0] en, input logic lz);
    exp_t e;
    logic all_zero;
    all_zero = 1'b1;
    for (int j = i; j < DIGITS; j++)
      if (v[4*j +: 4] != 4'h0) all_zero = 1'b0;
    if (en[i] && !(lz && i > 0 && all_zero)) begin
      e.an  = ~(4'b0001 << i);
      e.seg = ref_glyph(v[4*i +: 4]);
      e.dp  = ~dpv[i];
    end else begin
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
      e.dp  = 1'b1;
    end
    return e;
  endfunction

  // Shadow contents as the bench believes the DUT holds them.
  logic [15:0] sh_v;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_en;

  task automatic push_frame(input logic lz);
    for (int i = 0; i < DIGITS; i++)
      exp_q.push_back(ref_digit(i, sh_v, sh_dp, sh_en, lz));
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: slot timing derived from cycles since reset release
  // ---------------------------------------------------------------------------
  logic running = 1'b0;
  int   cyc     = 0;

  always @(posedge clk) if (running) cyc++;

  exp_t cur_exp;
  logic have_exp = 1'b0;

  always @(negedge clk) begin
    int p;
    int d;
    if (running && cyc > 0) begin
      p = (cyc - 1) % PRESCALE;
      d = ((cyc - 1) / PRESCALE) % DIGITS;
      check("frame_start", frame_start, (p == 0 && d == 0));
      if (p < BLANK) begin
        check("blank_an",  an,     4'b1111);
        check("blank_seg", seg,    7'b1111111);
        check("blank_dp",  dp_out, 1'b1);
      end else begin
        if (p == BLANK) begin
          if (exp_q.size() > 0) begin
            cur_exp  = exp_q.pop_front();
            have_exp = 1'b1;
          end else begin
            have_exp = 1'b0;
          end
        end
        if (have_exp) begin
          check($sformatf("show_an_d%0d", d),  an,     cur_exp.an);
          check($sformatf("show_seg_d%0d", d), seg,    cur_exp.seg);
          check($sformatf("show_dp_d%0d", d),  dp_out, cur_exp.dp);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic at_frame_start();
    return (cyc > 0) && ((cyc - 1) % PRESCALE == 0) &&
           (((cyc - 1) / PRESCALE) % DIGITS == 0);
  endfunction

  // Wait for the next frame start, optionally load, and queue the frame.
  task automatic run_frame(input logic do_load, input logic [15:0] v, input logic [3:0] dpv,
                           input logic [3:0] en, input logic lz);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!at_frame_start()) begin
      @(negedge clk);
      guard++;
      if (guard > 4 * DIGITS * PRESCALE) begin
        check("frame_wait_timeout", 0, 1);
        return;
      end
    end
    lz_suppress = lz;
    if (do_load) begin
      value    = v;
      dp_in    = dpv;
      digit_en = en;
      load     = 1'b1;
      sh_v     = v;
      sh_dp    = dpv;
      sh_en    = en;
    end
    push_frame(lz);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called right after run_frame returns (slot 0, phase 1); lands on phase 4.
  task automatic to_mid_show();
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset       = 1'b1;
    load        = 1'b0;
    value       = '0;
    dp_in       = '0;
    digit_en    = '0;
    lz_suppress = 1'b0;
    sh_v        = '0;
    sh_dp       = '0;
    sh_en       = '0;

    // Reset state, checked while reset is held.
    repeat (3) @(negedge clk);
    check("rst_an",   an,          4'b1111);
    check("rst_seg",  seg,         7'b1111111);
    check("rst_dp",   dp_out,      1'b1);
    check("rst_fs",   frame_start, 1'b0);

    // Basic scan: load is applied with reset so it lands on the first edge.
    value    = 16'h1234;
    digit_en = 4'hF;
    dp_in    = 4'h0;
    load     = 1'b1;
    sh_v     = 16'h1234;
    sh_en    = 4'hF;
    sh_dp    = 4'h0;
    @(negedge clk);
    reset   = 1'b0;
    cyc     = 0;
    running = 1'b1;
    push_frame(1'b0);
    @(negedge clk);
    load = 1'b0;

    // Second frame unchanged: frame_start periodicity.
    run_frame(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);

    // Leading-zero suppression.
    run_frame(1'b1, 16'h00A0, 4'h0, 4'hF, 1'b1);
    run_frame(1'b1, 16'h0000, 4'h0, 4'hF, 1'b1);

    // Enables and decimal points.
    run_frame(1'b1, 16'h8765, 4'b0100, 4'b0101, 1'b0);

    // Load mid-SHOW of digit 0: current digit holds, next frame shows F.
    run_frame(1'b1, 16'h1234, 4'h0, 4'hF, 1'b0);
    run_frame(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    to_mid_show();
    value = 16'h123F;
    load  = 1'b1;
    sh_v  = 16'h123F;
    @(negedge clk);
    load = 1'b0;
    run_frame(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);

    // Reset between edges during SHOW: outputs go inactive immediately.
    run_frame(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    to_mid_show();
    check("pre_rst_an_lit", an, 4'b1110);
    @(posedge clk);
    #2;
    reset   = 1'b1;
    running = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_an",  an,          4'b1111);
    check("async_rst_seg", seg,         7'b1111111);
    check("async_rst_dp",  dp_out,      1'b1);
    check("async_rst_fs",  frame_start, 1'b0);

    // Restart: scan resumes at digit 0 in BLANK.
    value    = 16'hBEEF;
    digit_en = 4'hF;
    dp_in    = 4'b0001;
    load     = 1'b1;
    sh_v     = 16'hBEEF;
    sh_en    = 4'hF;
    sh_dp    = 4'b0001;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    cyc     = 0;
    running = 1'b1;
    push_frame(1'b0);
    @(negedge clk);
    load = 1'b0;
    run_frame(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);

    repeat (DIGITS * PRESCALE + 8) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
